// File: rtl/lfsr_rand_bank.sv
// Bank of independent Galois LFSRs with reseed, warm-up and step handshake.
// Each channel also offers a word scaled into 0..limit-1.
module lfsr_rand_bank #(
    parameter int          WIDTH    = 16,
    parameter int          CHANNELS = 4,
    parameter logic [31:0] SEED     = 32'h0000ACE1,
    parameter int          WARMUP   = 32
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        seed_load,
    input  logic [WIDTH-1:0]            seed_in,
    input  logic                        step,
    input  logic [WIDTH-1:0]            limit,
    output logic                        ready,
    output logic                        rand_valid,
    output logic [CHANNELS*WIDTH-1:0]   rand_out,
    output logic [CHANNELS*WIDTH-1:0]   scaled_out
);

    typedef enum logic {
        S_WARM = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [31:0] TAPS32 =
        (WIDTH == 8)  ? 32'h000000B8 :
        (WIDTH == 16) ? 32'h0000B400 :
        (WIDTH == 24) ? 32'h00E10000 :
                        32'hA3000000;
    localparam logic [31:0] KMUL32 = 32'h9E3779B9;
    localparam logic [WIDTH-1:0] TAPS   = TAPS32[WIDTH-1:0];
    localparam logic [WIDTH-1:0] KMUL   = KMUL32[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];
    localparam logic [7:0] WARM_LAST =
        (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);
    localparam state_t S_INIT = (WARMUP == 0) ? S_RUN : S_WARM;

    function automatic logic [WIDTH-1:0] seed_of(
        input logic [WIDTH-1:0] base,
        input int unsigned      idx
    );
        logic [WIDTH-1:0] iw;
        logic [WIDTH-1:0] s;
        iw = WIDTH'(idx);
        s  = base + iw * KMUL;
        // an all-zero state would lock the LFSR forever
        if (s == '0) begin
            s = '1;
        end
        return s;
    endfunction

    state_t           state;
    state_t           state_nx;
    logic [7:0]       cnt;
    logic [7:0]       cnt_nx;
    logic             advance;
    logic             accept;
    logic [WIDTH-1:0] st    [CHANNELS];
    logic [WIDTH-1:0] nx    [CHANNELS];
    logic [2*WIDTH-1:0] prod [CHANNELS];

    assign ready = (state == S_RUN);

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            nx[i]   = (st[i] >> 1) ^ (st[i][0] ? TAPS : '0);
            prod[i] = {{WIDTH{1'b0}}, nx[i]} * {{WIDTH{1'b0}}, limit};
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        advance  = 1'b0;
        accept   = 1'b0;
        unique case (state)
            S_WARM: begin
                advance = 1'b1;
                cnt_nx  = cnt + 8'd1;
                if (cnt == WARM_LAST) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (step) begin
                    advance = 1'b1;
                    accept  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn || seed_load) begin
            state <= S_INIT;
            cnt   <= 8'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            rand_valid <= 1'b0;
            rand_out   <= '0;
            scaled_out <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                st[i] <= seed_of(SEED_W, i);
            end
        end else if (seed_load) begin
            // a step arriving with a reseed is dropped; outputs hold
            rand_valid <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                st[i] <= seed_of(seed_in, i);
            end
        end else begin
            rand_valid <= accept;
            for (int i = 0; i < CHANNELS; i++) begin
                if (advance) begin
                    st[i] <= nx[i];
                end
                if (accept) begin
                    rand_out[i*WIDTH +: WIDTH]   <= nx[i];
                    scaled_out[i*WIDTH +: WIDTH] <= prod[i][2*WIDTH-1:WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_rand_bank.sv
// Directed bench for lfsr_rand_bank: sequence, seeds, warm-up,
// reseed, period and reset during warm-up.
module tb_lfsr_rand_bank;

    logic clock;
    logic resetn;

    // a: 16-bit, 2 channels, no warm-up
    logic        seed_load_a;
    logic [15:0] seed_in_a;
    logic        step_a;
    logic [15:0] limit_a;
    logic        ready_a;
    logic        valid_a;
    logic [31:0] rand_a;
    logic [31:0] scaled_a;

    // b: defaults
    logic        seed_load_b;
    logic [15:0] seed_in_b;
    logic        step_b;
    logic [15:0] limit_b;
    logic        ready_b;
    logic        valid_b;
    logic [63:0] rand_b;
    logic [63:0] scaled_b;

    // c: 8-bit, 1 channel, no warm-up
    logic        seed_load_c;
    logic [7:0]  seed_in_c;
    logic        step_c;
    logic [7:0]  limit_c;
    logic        ready_c;
    logic        valid_c;
    logic [7:0]  rand_c;
    logic [7:0]  scaled_c;

    int checks;
    int failures;

    lfsr_rand_bank #(.WIDTH(16), .CHANNELS(2), .SEED(32'hACE1), .WARMUP(0)) u_a (
        .clock(clock), .resetn(resetn), .seed_load(seed_load_a),
        .seed_in(seed_in_a), .step(step_a), .limit(limit_a),
        .ready(ready_a), .rand_valid(valid_a),
        .rand_out(rand_a), .scaled_out(scaled_a)
    );

    lfsr_rand_bank u_b (
        .clock(clock), .resetn(resetn), .seed_load(seed_load_b),
        .seed_in(seed_in_b), .step(step_b), .limit(limit_b),
        .ready(ready_b), .rand_valid(valid_b),
        .rand_out(rand_b), .scaled_out(scaled_b)
    );

    lfsr_rand_bank #(.WIDTH(8), .CHANNELS(1), .SEED(32'hACE1), .WARMUP(0)) u_c (
        .clock(clock), .resetn(resetn), .seed_load(seed_load_c),
        .seed_in(seed_in_c), .step(step_c), .limit(limit_c),
        .ready(ready_c), .rand_valid(valid_c),
        .rand_out(rand_c), .scaled_out(scaled_c)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] succ16(input logic [15:0] s, input int n);
        logic [15:0] v;
        v = s;
        for (int k = 0; k < n; k++) begin
            v = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
        end
        return v;
    endfunction

    function automatic logic [7:0] succ8(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] w;
        logic [7:0]  m;
        logic [7:0]  exp8;
        logic [255:0] seen;
        int n;
        checks      = 0;
        failures    = 0;
        resetn      = 1'b0;
        seed_load_a = 1'b0; seed_in_a = 16'h0; step_a = 1'b0; limit_a = 16'd10;
        seed_load_b = 1'b0; seed_in_b = 16'h0; step_b = 1'b0; limit_b = 16'hFFFF;
        seed_load_c = 1'b0; seed_in_c = 8'h0;  step_c = 1'b0; limit_c = 8'd0;
        tick();
        tick();
        chk("rst_valid_a", valid_a, 0);
        chk("rst_rand_a", rand_a, 0);
        chk("rst_scaled_a", scaled_a, 0);
        chk("rst_ready_b", ready_b, 0);
        chk("rst_valid_b", valid_b, 0);
        chk("rst_rand_b", rand_b, 0);
        chk("rst_scaled_b", scaled_b, 0);
        chk("rst_rand_c", rand_c, 0);

        // warm-up on b with step held from release
        resetn = 1'b1;
        step_b = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk("warm_ready", ready_b, (k == 32));
            chk("warm_valid", valid_b, 0);
        end
        tick();
        w = succ16(16'hACE1, 33);
        chk("warm_valid33", valid_b, 1);
        chk("warm_ch0", rand_b[15:0], w);
        chk("warm_ch1", rand_b[31:16], succ16(16'h269A, 33));
        chk("warm_ch3", rand_b[63:48], succ16(16'h1A0C, 33));
        chk("warm_scaled0", scaled_b[15:0], w - 16'd1);
        tick();
        w = succ16(16'hACE1, 34);
        chk("stream_valid", valid_b, 1);
        chk("stream_ch0", rand_b[15:0], w);

        // reseed with zero while streaming, step stays high
        seed_load_b = 1'b1;
        seed_in_b   = 16'h0000;
        limit_b     = 16'h0000;
        tick();
        chk("reseed_valid", valid_b, 0);
        chk("reseed_ready", ready_b, 0);
        chk("reseed_hold", rand_b[15:0], w);
        seed_load_b = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk("reseed_warm_ready", ready_b, (k == 32));
            chk("reseed_warm_valid", valid_b, 0);
        end
        tick();
        chk("reseed_valid33", valid_b, 1);
        chk("reseed_ch0", rand_b[15:0], succ16(16'hFFFF, 33));
        chk("reseed_ch1", rand_b[31:16], succ16(16'h79B9, 33));
        chk("reseed_limit0", scaled_b, 0);
        step_b = 1'b0;
        tick();
        chk("idle_valid_b", valid_b, 0);

        // basic sequence and channel seeds on a
        chk("a_ready", ready_a, 1);
        chk("a_idle_valid", valid_a, 0);
        step_a = 1'b1;
        tick();
        chk("a_valid1", valid_a, 1);
        chk("a_rand0_1", rand_a[15:0], 16'hE270);
        chk("a_scaled0_1", scaled_a[15:0], 16'd8);
        chk("a_rand1_1", rand_a[31:16], 16'h134D);
        chk("a_scaled1_1", scaled_a[31:16], 16'd0);
        tick();
        chk("a_valid2", valid_a, 1);
        chk("a_rand0_2", rand_a[15:0], 16'h7138);
        chk("a_scaled0_2", scaled_a[15:0], 16'd4);
        step_a = 1'b0;
        tick();
        chk("a_valid_drop", valid_a, 0);
        chk("a_hold", rand_a[15:0], 16'h7138);

        // 8-bit period from seed E1
        seen = '0;
        seen[8'hE1] = 1'b1;
        exp8 = 8'hE1;
        step_c = 1'b1;
        for (int k = 1; k <= 255; k++) begin
            tick();
            m    = rand_c;
            exp8 = succ8(exp8);
            chk("per_valid", valid_c, 1);
            chk("per_word", m, exp8);
            chk("per_nonzero", (m == 8'h00), 0);
            if (k < 255) begin
                chk("per_norepeat", seen[m], 0);
                seen[m] = 1'b1;
            end
        end
        chk("per_return", rand_c, 8'hE1);
        step_c = 1'b0;

        // reset mid-warm-up on b
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        chk("mid_ready", ready_b, 0);
        resetn = 1'b0;
        tick();
        chk("mid_rst_ready", ready_b, 0);
        chk("mid_rst_valid", valid_b, 0);
        chk("mid_rst_rand", rand_b, 0);
        chk("mid_rst_scaled", scaled_b, 0);
        chk("mid_rst_rand_a", rand_a, 0);
        resetn = 1'b1;
        n = 0;
        while (!ready_b && n < 40) begin
            tick();
            n++;
        end
        chk("mid_rewarm_cycles", n, 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
